// File: rtl/dac_spi_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_frame_seq
// Purpose  : Multi-channel SPI DAC output sequencer. One accepted request
//            latches a word per channel; each enabled channel is shifted
//            MSB first in its own chip-select frame, in ascending channel
//            order. Masked channels take no time.
// Ports    : i_Clock        - system clock (sole clock)
//            i_Reset        - synchronous active-high reset
//            i_Data         - channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//            i_Channel_Mask - bit n = 1 sends channel n
//            i_Send         - request strobe
//            o_Ready        - high while a new request can be accepted
//            o_SPI_CS       - active-low chip select
//            o_SPI_Clock    - SCK, idles high, DAC samples on rising edge
//            o_SPI_Data     - MOSI, changes on SCK falling edges only
//            o_Channel      - index of the frame in progress (held when idle)
//            o_LDAC         - active-low DAC latch strobe
// Options  : DAC_SPI_LDAC_EN - when defined, an LDAC low pulse of
//            LDAC_CYCLES follows the last frame before o_Ready rises.
//            Otherwise o_LDAC is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_frame_seq #(
  parameter int DATA_WIDTH     = 24,
  parameter int CHANNELS       = 2,
  parameter int CLK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 2,
  parameter int LDAC_CYCLES    = 2,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_Data,
  input  logic [CHANNELS-1:0]            i_Channel_Mask,
  input  logic                           i_Send,
  output logic                           o_Ready,
  output logic                           o_SPI_CS,
  output logic                           o_SPI_Clock,
  output logic                           o_SPI_Data,
  output logic [CH_W-1:0]                o_Channel,
  output logic                           o_LDAC
);

  // Shared down-counter for LEAD, SCK half-periods, GAP and LDAC (all <= 16).
  localparam int CNT_W = 5;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BIT_W-1:0]               bit_q, bit_d;     // bits left after the current one
  logic                           phase_q, phase_d; // 0 = SCK low half, 1 = high half
  logic [CHANNELS-1:0]            mask_q, mask_d;   // channels still to send
  logic [CHANNELS*DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0]          shift_q, shift_d;
  logic [CH_W-1:0]                chan_q, chan_d;
  logic                           ready_q, ready_d;
  logic                           cs_q, cs_d;
  logic                           sck_q, sck_d;
  logic                           sdo_q, sdo_d;
  logic                           ldac_q, ldac_d;

  // Lowest pending channel. While idle the search runs on the live inputs so
  // the first frame can be loaded on the accept edge itself.
  logic [CHANNELS-1:0]            pick_mask;
  logic [CHANNELS*DATA_WIDTH-1:0] pick_data;
  logic [CH_W-1:0]                pick_idx;
  logic                           pick_found;
  logic [DATA_WIDTH-1:0]          pick_word;
  logic                           load;

  always_comb begin
    pick_mask  = (state_q == ST_IDLE) ? i_Channel_Mask : mask_q;
    pick_data  = (state_q == ST_IDLE) ? i_Data : data_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int n = CHANNELS - 1; n >= 0; n--) begin
      if (pick_mask[n]) begin
        pick_idx   = CH_W'(n);
        pick_found = 1'b1;
      end
    end
    pick_word = pick_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    data_d  = data_q;
    shift_d = shift_q;
    chan_d  = chan_q;
    ready_d = ready_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    ldac_d  = ldac_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_Send && ready_q && pick_found) begin
          data_d = i_Data;
          load   = 1'b1;
        end
      end

      ST_LEAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // First falling edge: the MSB is already on MOSI, keep it.
          state_d = ST_SHIFT;
          phase_d = 1'b0;
          sck_d   = 1'b0;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!phase_q) begin
          phase_d = 1'b1;
          sck_d   = 1'b1;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end else if (bit_q == '0) begin
          // LSB high half done: close the frame with SCK left high.
          state_d = ST_GAP;
          cs_d    = 1'b1;
          sdo_d   = 1'b0;
          cnt_d   = CNT_W'(CS_HIGH_CYCLES - 1);
        end else begin
          phase_d = 1'b0;
          sck_d   = 1'b0;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = bit_q - BIT_W'(1);
          sdo_d   = shift_q[DATA_WIDTH-2];
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pick_found) begin
          load = 1'b1;
        end else begin
`ifdef DAC_SPI_LDAC_EN
          state_d = ST_LDAC;
          ldac_d  = 1'b0;
          cnt_d   = CNT_W'(LDAC_CYCLES - 1);
`else
          state_d = ST_IDLE;
          ready_d = 1'b1;
`endif
        end
      end

`ifdef DAC_SPI_LDAC_EN
      ST_LDAC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          ldac_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cs_d    = 1'b1;
        sck_d   = 1'b1;
        sdo_d   = 1'b0;
        ldac_d  = 1'b1;
      end
    endcase

    // Start a frame for the lowest pending channel (from IDLE or GAP).
    if (load) begin
      state_d           = ST_LEAD;
      cnt_d             = CNT_W'(CLK_DIV - 1);
      bit_d             = BIT_W'(DATA_WIDTH - 1);
      phase_d           = 1'b1;
      mask_d            = pick_mask;
      mask_d[pick_idx]  = 1'b0;
      shift_d           = pick_word;
      sdo_d             = pick_word[DATA_WIDTH-1];
      chan_d            = pick_idx;
      cs_d              = 1'b0;
      sck_d             = 1'b1;
      ready_d           = 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      chan_q  <= '0;
      ready_q <= 1'b1;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      sdo_q   <= 1'b0;
      ldac_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      chan_q  <= chan_d;
      ready_q <= ready_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      ldac_q  <= ldac_d;
    end
  end

  assign o_Ready     = ready_q;
  assign o_SPI_CS    = cs_q;
  assign o_SPI_Clock = sck_q;
  assign o_SPI_Data  = sdo_q;
  assign o_Channel   = chan_q;
`ifdef DAC_SPI_LDAC_EN
  assign o_LDAC      = ldac_q;
`else
  assign o_LDAC      = 1'b1;
`endif

endmodule
`default_nettype wire
